// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// Holds the request/response payload structs, the arbiter state encoding
// and the default master count used when the top is instantiated bare.
package mem_arb_pkg;

    localparam int MEM_ARB_N_MST = 2;
    localparam int N_AW          = 32;
    localparam int N_DW          = 32;
    localparam int N_BE          = N_DW / 8;

    typedef struct packed {
        logic [N_AW-1:0] addr;
        logic [N_DW-1:0] wdata;
        logic [N_BE-1:0] be;
        logic            we;
    } mem_req_t;

    typedef struct packed {
        logic [N_DW-1:0] rdata;
        logic            err;
    } mem_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_rr_arb.sv
// Combinational round-robin picker shared by the interconnect arbiters.
// Starting at index ptr and wrapping N-1 -> 0, the first requester found
// gets a one-hot grant. With no requests the grant is all zero.
module mem_arb_rr_arb #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found_s;

    // Scan requesters in rotated order from ptr and grant the first one seen
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!found_s && req[j] && (j == ((int'(ptr) + i) % N))) begin
                    gnt[j]  = 1'b1;
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// N-master arbiter in front of a single mem_req/mem_resp slave port.
// One transaction in flight at a time: the grant is taken in IDLE, the
// owner's request passes through in REQ, and its response passes back in
// RESP; the grant is released only when that response handshake completes.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (index 0
// highest, no rotating pointer); default is round-robin.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int N_MST = MEM_ARB_N_MST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_MST-1:0]      m_req_valid,
    output logic [N_MST-1:0]      m_req_ready,
    input  mem_req_t [N_MST-1:0]  m_req,
    output logic [N_MST-1:0]      m_resp_valid,
    input  logic [N_MST-1:0]      m_resp_ready,
    output mem_resp_t             m_resp,
    output logic                  s_req_valid,
    input  logic                  s_req_ready,
    output mem_req_t              s_req,
    input  logic                  s_resp_valid,
    output logic                  s_resp_ready,
    input  mem_resp_t             s_resp,
    output logic [N_MST-1:0]      grant_o,
    output logic                  busy_o
);

    localparam int PW    = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int REQ_W = $bits(mem_req_t);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [N_MST-1:0] grant_q;
    logic [N_MST-1:0] grant_d;
    logic [N_MST-1:0] gnt_s;
    logic [PW-1:0]    ptr_s;
    logic             sel_req_valid_s;
    logic             sel_resp_ready_s;
    logic [REQ_W-1:0] sel_req_s;
    logic             s_req_fire_s;
    logic             s_resp_fire_s;

    // Pick the candidate owner from the live requests and the search start
    mem_arb_rr_arb #(
        .N  (N_MST),
        .PW (PW)
    ) u_rr_arb (
        .req (m_req_valid),
        .ptr (ptr_s),
        .gnt (gnt_s)
    );

    // Gather the owner's signals; grant is one-hot or zero so an AND-OR mux is safe
    always_comb begin
        sel_req_valid_s  = |(m_req_valid & grant_q);
        sel_resp_ready_s = |(m_resp_ready & grant_q);
        sel_req_s        = '0;
        for (int i = 0; i < N_MST; i++) begin
            sel_req_s = sel_req_s | (m_req[i] & {REQ_W{grant_q[i]}});
        end
    end

    // Route request and response handshakes for the owner only, by phase
    always_comb begin
        m_req_ready  = '0;
        m_resp_valid = '0;
        m_resp       = '0;
        s_req_valid  = 1'b0;
        s_req        = '0;
        s_resp_ready = 1'b0;
        case (state_q)
            ARB_REQ: begin
                s_req_valid = sel_req_valid_s;
                s_req       = mem_req_t'(sel_req_s);
                m_req_ready = grant_q & {N_MST{s_req_ready}};
            end
            ARB_RESP: begin
                s_resp_ready = sel_resp_ready_s;
                m_resp_valid = grant_q & {N_MST{s_resp_valid}};
                m_resp       = s_resp;
            end
            default: begin
                s_req_valid = 1'b0;
            end
        endcase
    end

    assign s_req_fire_s  = s_req_valid & s_req_ready;
    assign s_resp_fire_s = s_resp_valid & s_resp_ready;

    // Phase sequencing: grant in IDLE, wait request accept, wait response accept
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (|m_req_valid) begin
                    state_d = ARB_REQ;
                    grant_d = gnt_s;
                end else begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            ARB_REQ: begin
                if (s_req_fire_s) begin
                    state_d = ARB_RESP;
                end else begin
                    state_d = ARB_REQ;
                end
            end
            ARB_RESP: begin
                if (s_resp_fire_s) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end else begin
                    state_d = ARB_RESP;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and grant registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at index 0
    assign ptr_s = '0;
`else
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] g_idx_s;

    // Encode the one-hot owner as an index for the pointer update
    always_comb begin
        g_idx_s = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (grant_q[i]) begin
                g_idx_s = PW'(i);
            end else begin
                g_idx_s = g_idx_s;
            end
        end
    end

    // Move the search start just past the owner once its response completes
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == ARB_RESP) && s_resp_fire_s) begin
            if (g_idx_s == PW'(N_MST - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = g_idx_s + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_s = ptr_q;
`endif

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb with four masters: directed scenarios with
// literal expectations, then randomized traffic against a transaction-level
// reference model that is compared with the DUT on every negative clock edge.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int NM = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NM-1:0]      m_req_valid;
    logic [NM-1:0]      m_req_ready;
    mem_req_t [NM-1:0]  m_req;
    logic [NM-1:0]      m_resp_valid;
    logic [NM-1:0]      m_resp_ready;
    mem_resp_t          m_resp;
    logic               s_req_valid;
    logic               s_req_ready;
    mem_req_t           s_req;
    logic               s_resp_valid;
    logic               s_resp_ready;
    mem_resp_t          s_resp;
    logic [NM-1:0]      grant_o;
    logic               busy_o;

    int n_chk  = 0;
    int n_fail = 0;
    int n_sreq_hs = 0;
    int n_sresp_hs = 0;

    // reference model: owner, whether its request was taken, search start
    logic          own_vld;
    logic [1:0]    own_q;
    logic          req_done;
    logic [1:0]    ptr_m;
    logic [NM-1:0] acc_mask;

    mem_arb #(.N_MST(NM)) dut (
        .clk          (clk),
        .rst          (rst),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req        (m_req),
        .m_resp_valid (m_resp_valid),
        .m_resp_ready (m_resp_ready),
        .m_resp       (m_resp),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req        (s_req),
        .s_resp_valid (s_resp_valid),
        .s_resp_ready (s_resp_ready),
        .s_resp       (s_resp),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic mem_req_t rnd_req();
        mem_req_t r;
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.be    = 4'($urandom);
        r.we    = 1'($urandom);
        return r;
    endfunction

    function automatic mem_resp_t rnd_resp();
        mem_resp_t r;
        r.rdata = $urandom;
        r.err   = 1'($urandom);
        return r;
    endfunction

    // first valid master at or after p, wrapping modulo 4 via 2-bit arithmetic
    function automatic logic [1:0] pick(input logic [NM-1:0] v, input logic [1:0] p);
        logic [1:0] j;
        logic [1:0] start;
        start = FIXED ? 2'd0 : p;
        for (int k = 0; k < NM; k++) begin
            j = start + 2'(k);
            if (v[j]) return j;
        end
        return 2'd0;
    endfunction

    // advance the reference model on each clock edge from the inputs the DUT saw
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own_vld  <= 1'b0;
            own_q    <= 2'd0;
            req_done <= 1'b0;
            ptr_m    <= 2'd0;
            acc_mask <= 4'b0;
        end else begin
            acc_mask <= 4'b0;
            if (!own_vld) begin
                if (|m_req_valid) begin
                    own_vld <= 1'b1;
                    own_q   <= pick(m_req_valid, ptr_m);
                end
            end else if (!req_done) begin
                if (m_req_valid[own_q] && s_req_ready) begin
                    req_done <= 1'b1;
                    acc_mask <= 4'b1 << own_q;
                end
            end else if (s_resp_valid && m_resp_ready[own_q]) begin
                own_vld  <= 1'b0;
                req_done <= 1'b0;
                ptr_m    <= own_q + 2'd1;
            end
        end
    end

    // count slave-side handshakes actually passed by the DUT
    always @(posedge clk) begin
        if (!rst && s_req_valid && s_req_ready) n_sreq_hs <= n_sreq_hs + 1;
        if (!rst && s_resp_valid && s_resp_ready) n_sresp_hs <= n_sresp_hs + 1;
    end

    // compare every output with the model's expectation mid-cycle
    always @(negedge clk) begin
        logic [NM-1:0] e_grant;
        logic [NM-1:0] e_mrr;
        logic [NM-1:0] e_mrv;
        logic          e_busy;
        logic          e_srv;
        logic          e_srr;
        mem_req_t      e_sreq;
        mem_resp_t     e_mresp;
        e_grant = '0; e_mrr = '0; e_mrv = '0;
        e_busy = 1'b0; e_srv = 1'b0; e_srr = 1'b0;
        e_sreq = '0; e_mresp = '0;
        if (!rst && own_vld) begin
            e_grant[own_q] = 1'b1;
            e_busy = 1'b1;
            if (!req_done) begin
                e_srv = m_req_valid[own_q];
                e_sreq = m_req[own_q];
                e_mrr[own_q] = s_req_ready;
            end else begin
                e_srr = m_resp_ready[own_q];
                e_mrv[own_q] = s_resp_valid;
                e_mresp = s_resp;
            end
        end
        chk("grant_o",      128'(grant_o),      128'(e_grant));
        chk("busy_o",       128'(busy_o),       128'(e_busy));
        chk("s_req_valid",  128'(s_req_valid),  128'(e_srv));
        chk("s_req",        128'(s_req),        128'(e_sreq));
        chk("m_req_ready",  128'(m_req_ready),  128'(e_mrr));
        chk("s_resp_ready", 128'(s_resp_ready), 128'(e_srr));
        chk("m_resp_valid", 128'(m_resp_valid), 128'(e_mrv));
        chk("m_resp",       128'(m_resp),       128'(e_mresp));
    end

    // one full transaction with an always-ready slave; checks who got the grant
    task automatic txn(input logic [NM-1:0] vmask, input logic [NM-1:0] exp_g, input string nm);
        int n;
        @(posedge clk); #1;
        for (int i = 0; i < NM; i++) if (vmask[i]) m_req[i] = rnd_req();
        m_req_valid  = vmask;
        s_req_ready  = 1'b1;
        s_resp_valid = 1'b1;
        m_resp_ready = '1;
        s_resp       = rnd_resp();
        n = 0;
        do begin @(negedge clk); n++; end while (grant_o == '0 && n < 20);
        chk(nm, 128'(grant_o), 128'(exp_g));
        @(posedge clk); #1;
        m_req_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (busy_o && n < 20);
        chk({nm, " release"}, 128'(busy_o), 128'(1'b0));
    endtask

    initial begin
        int hs0;
        int rs0;
        mem_req_t  a_req;
        mem_resp_t a_resp;
        rst = 1'b1;
        m_req_valid = '0; m_resp_ready = '0; s_req_ready = 1'b0; s_resp_valid = 1'b0;
        s_resp = '0;
        for (int i = 0; i < NM; i++) m_req[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset grant", 128'(grant_o), 128'(4'b0));
        chk("reset busy",  128'(busy_o),  128'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;

        // single master: one arbitration cycle, then pass-through
        a_req = rnd_req();
        a_resp = rnd_resp();
        @(posedge clk); #1;
        m_req[0] = a_req; m_req_valid = 4'b0001; s_req_ready = 1'b1;
        @(negedge clk);
        chk("t1 arb grant", 128'(grant_o), 128'(4'b0));
        chk("t1 arb srv",   128'(s_req_valid), 128'(1'b0));
        @(negedge clk);
        chk("t1 grant",   128'(grant_o), 128'(4'b0001));
        chk("t1 srv",     128'(s_req_valid), 128'(1'b1));
        chk("t1 mrr",     128'(m_req_ready), 128'(4'b0001));
        chk("t1 payload", 128'(s_req), 128'(a_req));
        @(posedge clk); #1;
        m_req_valid = '0; s_resp_valid = 1'b1; s_resp = a_resp; m_resp_ready = 4'b0001;
        @(negedge clk);
        chk("t1 mrv",  128'(m_resp_valid), 128'(4'b0001));
        chk("t1 resp", 128'(m_resp), 128'(a_resp));
        @(posedge clk); #1;
        s_resp_valid = 1'b0; m_resp_ready = '0;
        @(negedge clk);
        chk("t1 grant released", 128'(grant_o), 128'(4'b0));

        // reset while waiting for a response clears outputs at once
        @(posedge clk); #1;
        m_req[3] = rnd_req(); m_req_valid = 4'b1000; s_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_req_valid = '0; s_req_ready = 1'b0; s_resp_valid = 1'b1; m_resp_ready = '0;
        @(negedge clk);
        chk("t5 in resp", 128'(grant_o), 128'(4'b1000));
        #2;
        rst = 1'b1;
        #1;
        chk("t5 async grant", 128'(grant_o), 128'(4'b0));
        chk("t5 async busy",  128'(busy_o),  128'(1'b0));
        chk("t5 async mrv",   128'(m_resp_valid), 128'(4'b0));
        chk("t5 async srr",   128'(s_resp_ready), 128'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0; s_resp_valid = 1'b0;

        // pointer starts at 0 again: alternation, then wrap past index 3
        txn(4'b0011, 4'b0001, "t2 first");
        txn(4'b0011, FIXED ? 4'b0001 : 4'b0010, "t2 second");
        txn(4'b0011, 4'b0001, "t3 third");
        txn(4'b0011, FIXED ? 4'b0001 : 4'b0010, "t3 fourth");
        txn(4'b0100, 4'b0100, "t6 prime");
        txn(4'b0110, 4'b0010, "t6 wrap");
        txn(4'b0101, FIXED ? 4'b0001 : 4'b0100, "t6 ptr after");

        // slave stalls: request held 5 cycles, response held 3 cycles
        hs0 = n_sreq_hs; rs0 = n_sresp_hs;
        @(posedge clk); #1;
        m_req[0] = rnd_req(); m_req_valid = 4'b0001;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; m_resp_ready = '0;
        repeat (6) @(negedge clk);
        chk("t4 grant held", 128'(grant_o), 128'(4'b0001));
        @(posedge clk); #1;
        s_req_ready = 1'b1;
        @(posedge clk); #1;
        m_req_valid = '0; s_req_ready = 1'b0; s_resp_valid = 1'b1; s_resp = rnd_resp();
        repeat (3) @(negedge clk);
        chk("t4 resp stalled", 128'(s_resp_ready), 128'(1'b0));
        @(posedge clk); #1;
        m_resp_ready = 4'b0001;
        @(posedge clk); #1;
        s_resp_valid = 1'b0; m_resp_ready = '0;
        @(negedge clk);
        chk("t4 req count",  128'(n_sreq_hs - hs0),  128'(1));
        chk("t4 resp count", 128'(n_sresp_hs - rs0), 128'(1));

        // randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NM; i++) begin
                if (acc_mask[i]) begin
                    if ($urandom_range(1, 0) == 0) m_req_valid[i] = 1'b0;
                    else m_req[i] = rnd_req();
                end else if (!m_req_valid[i]) begin
                    if ($urandom_range(2, 0) == 0) begin
                        m_req_valid[i] = 1'b1;
                        m_req[i] = rnd_req();
                    end
                end else if ($urandom_range(31, 0) == 0) begin
                    m_req_valid[i] = 1'b0;
                end
            end
            s_req_ready  = 1'($urandom_range(1, 0));
            s_resp_valid = ($urandom_range(3, 0) != 0);
            s_resp       = rnd_resp();
            m_resp_ready = 4'($urandom);
        end

        @(posedge clk); #1;
        m_req_valid = '0;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
